// File: rtl/fmult_pkg.sv
// fmult_pkg: shared types and defaults for the bfloat16 multiplier scheduler.
package fmult_pkg;
  typedef logic [15:0] fp16_t;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} sched_state_t;
  localparam int FMULT_LAT = 2;
endpackage

// File: rtl/fmult_rr_arb.sv
// fmult_rr_arb: combinational round-robin pick, search starts at ptr and wraps.
module fmult_rr_arb #(
  parameter int N = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);
  always_comb begin
    gnt = '0;
    gnt_id = '0;
    // walk from the farthest offset down so the nearest valid requester wins last
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + i) % N] = 1'b1;
        gnt_id = ID_W'((int'(ptr) + i) % N);
      end
    end
  end
endmodule

// File: rtl/fmult_sched.sv
// fmult_sched: round-robin sharing of one pipelined bf16 multiplier with tagged responses and drain.
// Define FMULT_SCHED_STATS_EN to add per-requester saturating grant counters on stat_grants.
module fmult_sched
  import fmult_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int MULT_LAT = FMULT_LAT,
  parameter int CNT_W = 16
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*16-1:0] req_a,
  input  logic [N_REQ*16-1:0] req_b,
  output logic [N_REQ-1:0]   rsp_valid,
  output fp16_t              rsp_data,
  output fp16_t              mult_a,
  output fp16_t              mult_b,
  input  fp16_t              mult_p,
  input  logic               drain_req,
  output logic               drain_done,
  output logic               busy
`ifdef FMULT_SCHED_STATS_EN
  ,
  output logic [N_REQ*CNT_W-1:0] stat_grants
`endif
);
  localparam int ID_W = $clog2(N_REQ);
  // one stage beyond MULT_LAT so the tag lines up with mult_p at the response register
  localparam int DEPTH = MULT_LAT + 1;
  if (N_REQ < 2 || N_REQ > 8 || MULT_LAT < 1 || CNT_W < 1) begin : g_bad_cfg
    $error("fmult_sched: N_REQ must be 2..8, MULT_LAT >= 1, CNT_W >= 1");
  end
  sched_state_t state, state_nx;
  logic [ID_W-1:0] rr_ptr, gnt_id;
  logic [N_REQ-1:0] gnt;
  logic [DEPTH-1:0] tag_v;
  logic [ID_W-1:0] tag_id [DEPTH];
  logic acc;
  fmult_rr_arb #(.N(N_REQ), .ID_W(ID_W)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt(gnt),
    .gnt_id(gnt_id)
  );
  assign req_ready = (state == RUN && !drain_req && !ap_rst) ? gnt : '0;
  assign acc = |req_ready;
  assign busy = |tag_v;
  always_comb begin
    state_nx = state == RUN   ? (drain_req ? DRAIN : RUN) :
               state == DRAIN ? (!drain_req ? RUN : busy ? DRAIN : DONE) :
                                (drain_req ? DONE : RUN);
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= RUN;
      rr_ptr <= '0;
      tag_v <= '0;
      mult_a <= '0;
      mult_b <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
      drain_done <= 1'b0;
    end else begin
      state <= state_nx;
      drain_done <= state_nx == DONE;
      tag_v <= {tag_v[DEPTH-2:0], acc};
      rsp_valid <= tag_v[DEPTH-1] ? N_REQ'(1) << tag_id[DEPTH-1] : '0;
      if (tag_v[DEPTH-1]) rsp_data <= mult_p;
      if (acc) begin
        mult_a <= req_a[16*gnt_id +: 16];
        mult_b <= req_b[16*gnt_id +: 16];
        rr_ptr <= gnt_id == ID_W'(N_REQ - 1) ? '0 : gnt_id + 1'b1;
      end
    end
  end
  always_ff @(posedge ap_clk) begin
    tag_id[0] <= gnt_id;
    for (int i = 1; i < DEPTH; i++) tag_id[i] <= tag_id[i-1];
  end
`ifdef FMULT_SCHED_STATS_EN
  for (genvar i = 0; i < N_REQ; i++) begin : g_stat
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge ap_clk) begin
      cnt <= ap_rst ? '0 : (req_ready[i] && !(&cnt)) ? cnt + 1'b1 : cnt;
    end
    assign stat_grants[i*CNT_W +: CNT_W] = cnt;
  end
`endif
endmodule

// File: tb/tb_fmult_sched.sv
// tb_fmult_sched: randomized and directed checks of fmult_sched against a queue-based model.
// Includes a behavioural 2-stage bf16 multiplier standing in for fmult_0.
module tb_fmult_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [3:0] req_valid, req_ready, rsp_valid;
  logic [63:0] req_a, req_b;
  logic [15:0] rsp_data, mult_a, mult_b, mult_p, p1;
  logic drain_req, drain_done, busy;
`ifdef FMULT_SCHED_STATS_EN
  logic [15:0] stat_grants;
`endif
  fmult_sched #(.N_REQ(4), .MULT_LAT(2), .CNT_W(4)) dut (
    .ap_clk(clk),
    .ap_rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .mult_a(mult_a),
    .mult_b(mult_b),
    .mult_p(mult_p),
    .drain_req(drain_req),
    .drain_done(drain_done),
    .busy(busy)
`ifdef FMULT_SCHED_STATS_EN
    ,
    .stat_grants(stat_grants)
`endif
  );
  function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] m;
    int e;
    if (a[14:7] == 8'd0 || b[14:7] == 8'd0) return {a[15] ^ b[15], 15'd0};
    m = {1'b1, a[6:0]} * {1'b1, b[6:0]};
    e = int'(a[14:7]) + int'(b[14:7]) - 127;
    if (m[15]) begin
      e++;
      return {a[15] ^ b[15], e[7:0], m[14:8]};
    end
    return {a[15] ^ b[15], e[7:0], m[13:7]};
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      p1 <= '0;
      mult_p <= '0;
    end else begin
      p1 <= bf16_mul(mult_a, mult_b);
      mult_p <= p1;
    end
  end
  int checks = 0;
  int errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  typedef struct {
    int id;
    logic [15:0] p;
    int due;
  } op_t;
  op_t q[$];
  int cyc = 0;
  int m_ptr = 0;
  int m_state = 0;
  int mcnt[4] = '{0, 0, 0, 0};
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    logic [3:0] exp_rdy, exp_rsp;
    logic [15:0] exp_data;
    logic mbusy;
    int w;
    if (rst) begin
      check("rst_ready", req_ready, 0);
      q.delete();
      m_ptr = 0;
      m_state = 0;
      for (int i = 0; i < 4; i++) mcnt[i] = 0;
    end else begin
      exp_rsp = '0;
      exp_data = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_rsp = 4'b1 << q[0].id;
        exp_data = q[0].p;
        void'(q.pop_front());
      end
      check("rsp_valid", rsp_valid, exp_rsp);
      if (exp_rsp != 0) check("rsp_data", rsp_data, exp_data);
      mbusy = q.size() > 0;
      check("busy", busy, mbusy);
      check("drain_done", drain_done, m_state == 2);
`ifdef FMULT_SCHED_STATS_EN
      for (int i = 0; i < 4; i++) check("stat", stat_grants[4*i +: 4], mcnt[i]);
`endif
      exp_rdy = '0;
      w = -1;
      if (m_state == 0 && !drain_req)
        for (int i = 0; i < 4; i++) if (w < 0 && req_valid[(m_ptr + i) % 4]) w = (m_ptr + i) % 4;
      if (w >= 0) exp_rdy[w] = 1'b1;
      check("ready", req_ready, exp_rdy);
      if (w >= 0) begin
        q.push_back('{w, bf16_mul(req_a[16*w +: 16], req_b[16*w +: 16]), cyc + 4});
        m_ptr = (w + 1) % 4;
        if (mcnt[w] < 15) mcnt[w]++;
      end
      case (m_state)
        0: m_state = drain_req ? 1 : 0;
        1: m_state = !drain_req ? 0 : (mbusy ? 1 : 2);
        default: m_state = drain_req ? 2 : 0;
      endcase
    end
  end
  task automatic chk_reset();
    check("rv_ready", req_ready, 0);
    check("rv_rsp_valid", rsp_valid, 0);
    check("rv_rsp_data", rsp_data, 0);
    check("rv_mult_a", mult_a, 0);
    check("rv_mult_b", mult_b, 0);
    check("rv_drain_done", drain_done, 0);
    check("rv_busy", busy, 0);
  endtask
  task automatic pulse_rst();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  function automatic logic [15:0] rnd_fp();
    logic [7:0] e;
    logic [6:0] m;
    e = 8'(100 + $urandom_range(0, 50));
    m = 7'($urandom);
    return {1'($urandom), e, m};
  endfunction
  initial begin
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    drain_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset();
    req_a[15:0] = 16'h3FC0;
    req_b[15:0] = 16'h4010;
    req_valid = 4'b0001;
    @(negedge clk);
    check("so_ready", req_ready, 4'b0001);
    @(posedge clk);
    #1 req_valid = '0;
    repeat (3) @(posedge clk);
    #1 check("so_rsp_valid", rsp_valid, 4'b0001);
    check("so_rsp_data", rsp_data, 16'h4058);
    pulse_rst();
    req_a[31:16] = 16'h4300;
    req_b[31:16] = 16'h3C80;
    req_a[47:32] = 16'h4000;
    req_b[47:32] = 16'h4040;
    req_a[63:48] = 16'h3F80;
    req_b[63:48] = 16'hBF80;
    req_valid = 4'hF;
    @(negedge clk);
    check("rr_first", req_ready, 4'b0001);
    repeat (8) @(posedge clk);
    #1 req_valid = '0;
    repeat (5) @(posedge clk);
    #1 req_valid = 4'b0100;
    @(posedge clk);
    #1 req_valid = 4'b0010;
    @(negedge clk);
    check("wrap_ready", req_ready, 4'b0010);
    @(posedge clk);
    #1 req_valid = 4'b0110;
    @(negedge clk);
    check("skip_ready", req_ready, 4'b0100);
    @(posedge clk);
    #1 req_valid = 4'hF;
    repeat (3) @(posedge clk);
    #1 drain_req = 1'b1;
    #1 check("drain_ready", req_ready, 0);
    for (int i = 0; i < 20 && !drain_done; i++) @(posedge clk) #2;
    check("drain_to", drain_done, 1);
    check("drain_busy", busy, 0);
    drain_req = 1'b0;
    @(posedge clk);
    #1 check("resume", req_ready != 0, 1);
    req_valid = 4'b0011;
    repeat (2) @(posedge clk);
    #1 req_valid = '0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 check("rst_no_rsp", rsp_valid, 0);
    end
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1 rst = $urandom_range(0, 150) == 0;
      req_valid = 4'($urandom);
      for (int j = 0; j < 4; j++) begin
        req_a[16*j +: 16] = rnd_fp();
        req_b[16*j +: 16] = rnd_fp();
      end
      if ($urandom_range(0, 25) == 0) drain_req = !drain_req;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    req_valid = '0;
    drain_req = 1'b0;
    repeat (8) @(posedge clk);
`ifdef FMULT_SCHED_STATS_EN
    pulse_rst();
    req_valid = 4'b0100;
    repeat (20) @(posedge clk);
    #1 req_valid = '0;
    check("stat2_sat", stat_grants[11:8], 4'hF);
    check("stat_others", {stat_grants[15:12], stat_grants[7:0]}, 0);
    repeat (5) @(posedge clk);
`endif
    #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
